// File: rtl/jericalla_fetch.sv
// Instruction fetch/issue for the Jericalla core: loadable imem, PC, RAW-hazard bubble insertion.
// Latency: start sampled at edge E0 puts imem[0] on instruccion after E0; one word per edge after that.
// Backpressure: none from the core; hazards stall the PC and issue NOP bubbles instead.
module jericalla_fetch #(
    parameter int              DEPTH      = 64,
    parameter int              ADDR_W     = 6,
    parameter logic [2:0]      NOP_OPCODE = 3'b111,
    parameter logic [7:0]      WB_MASK    = 8'b0001_1111
) (
    input  logic              clk_jericalla,
    input  logic              rst_jericalla,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [0:17]       load_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [0:17]       instruccion,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              bubble,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN1, S_DRAIN2} state_t;

    localparam logic [0:17]       NOP_WORD = {15'd0, NOP_OPCODE};
    localparam logic [ADDR_W-1:0] ADDR0    = '0;
    localparam logic [ADDR_W-1:0] ADDR1    = ADDR_W'(1);

    logic [0:17]       imem [DEPTH];
    state_t            state, state_n;
    logic [ADDR_W-1:0] pc_n;
    logic [ADDR_W-1:0] last_q;
    logic [0:17]       instr_n;
    logic              bubble_n, done_n;
    logic              issue_real, issue_wv;
    logic [4:0]        issue_wa;
    logic [4:0]        h1_wa, h2_wa;
    logic              h1_v, h2_v;
    logic [0:17]       cand;
    logic [4:0]        cand_ra1, cand_ra2;
    logic              hazard;

    assign busy     = (state != S_IDLE);
    assign cand     = imem[pc];
    assign cand_ra2 = cand[0:4];
    assign cand_ra1 = cand[5:9];

    // Register 0 is an ordinary register for hazard purposes.
    assign hazard = (h1_v && (cand_ra1 == h1_wa || cand_ra2 == h1_wa)) ||
                    (h2_v && (cand_ra1 == h2_wa || cand_ra2 == h2_wa));

    always_ff @(posedge clk_jericalla) begin
        if (load_we && state == S_IDLE && !start) begin
            imem[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        instr_n    = NOP_WORD;
        bubble_n   = 1'b0;
        done_n     = 1'b0;
        issue_real = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    instr_n    = imem[ADDR0];
                    issue_real = 1'b1;
                    if (last_addr == ADDR0) begin
                        state_n = S_DRAIN1;
                    end else begin
                        pc_n    = ADDR1;
                        state_n = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (hazard) begin
                    bubble_n = 1'b1;
                end else begin
                    instr_n    = cand;
                    issue_real = 1'b1;
                    if (pc == last_q) begin
                        state_n = S_DRAIN1;
                    end else begin
                        pc_n = pc + ADDR1;
                    end
                end
            end
            S_DRAIN1: state_n = S_DRAIN2;
            S_DRAIN2: begin
                state_n = S_IDLE;
                done_n  = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Bubbles and drain NOPs never count as producers, whatever the mask says.
    assign issue_wv = issue_real & WB_MASK[instr_n[15:17]];
    assign issue_wa = instr_n[10:14];

    always_ff @(posedge clk_jericalla) begin
        if (rst_jericalla) begin
            state       <= S_IDLE;
            pc          <= '0;
            last_q      <= '0;
            instruccion <= NOP_WORD;
            bubble      <= 1'b0;
            done        <= 1'b0;
            h1_wa       <= '0;
            h1_v        <= 1'b0;
            h2_wa       <= '0;
            h2_v        <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instruccion <= instr_n;
            bubble      <= bubble_n;
            done        <= done_n;
            if (state == S_IDLE && start) begin
                last_q <= last_addr;
            end
            h2_wa <= h1_wa;
            h2_v  <= h1_v;
            h1_wa <= issue_wa;
            h1_v  <= issue_wv;
        end
    end

endmodule

// File: tb/tb_jericalla_fetch.sv
// Directed bench for jericalla_fetch: table of per-edge vectors plus hand-written corner sequences.
module tb_jericalla_fetch;

    logic        clk_jericalla = 1'b0;
    logic        rst_jericalla;
    logic        load_we;
    logic [5:0]  load_addr;
    logic [0:17] load_data;
    logic        start;
    logic [5:0]  last_addr;
    logic [0:17] instruccion;
    logic [5:0]  pc;
    logic        busy, bubble, done;

    int checks   = 0;
    int failures = 0;

    logic [0:17] cap [64];

    jericalla_fetch dut (
        .clk_jericalla (clk_jericalla),
        .rst_jericalla (rst_jericalla),
        .load_we       (load_we),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .start         (start),
        .last_addr     (last_addr),
        .instruccion   (instruccion),
        .pc            (pc),
        .busy          (busy),
        .bubble        (bubble),
        .done          (done)
    );

    initial forever #5 clk_jericalla = ~clk_jericalla;

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [0:17] data;
        logic        st;
        logic [5:0]  last;
        logic [0:17] e_instr;
        logic [5:0]  e_pc;
        logic        e_busy;
        logic        e_bub;
        logic        e_done;
    } vec_t;

    function automatic logic [0:17] w(input int ra2, input int ra1, input int wa, input int op);
        logic [4:0] a2, a1, d;
        logic [2:0] o;
        a2 = ra2[4:0];
        a1 = ra1[4:0];
        d  = wa[4:0];
        o  = op[2:0];
        return {a2, a1, d, o};
    endfunction

    function automatic vec_t mk(input logic we, input int addr, input logic [0:17] data,
                                input logic st, input int last, input logic [0:17] ei,
                                input int epc, input logic eb, input logic ebub, input logic ed);
        vec_t v;
        v.we = we;  v.addr = addr[5:0];  v.data = data;
        v.st = st;  v.last = last[5:0];
        v.e_instr = ei;  v.e_pc = epc[5:0];
        v.e_busy = eb;   v.e_bub = ebub;  v.e_done = ed;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_jericalla);
        #1;
    endtask

    task automatic load(input int addr, input logic [0:17] data);
        load_we = 1'b1; load_addr = addr[5:0]; load_data = data;
        tick();
        load_we = 1'b0;
    endtask

    task automatic run_capture(input int last, output int nbub, output int ncyc);
        int n;
        start = 1'b1; last_addr = last[5:0];
        tick();
        start = 1'b0; load_we = 1'b0;
        cap[0] = instruccion;
        nbub = int'(bubble);
        n = 1;
        while (!done && n < 64) begin
            tick();
            cap[n] = instruccion;
            nbub += int'(bubble);
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL run_timeout: got done=0 after %0d edges expected done=1", n);
        end
        ncyc = n;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check(nm, busy, 0);
    endtask

    localparam logic [0:17] NOP = 18'h7;

    initial begin
        vec_t tbl [17];
        logic [0:17] i0, i1, i2, j0, j1, k0, k1, k2, k0n, bad, s0;
        logic [0:17] m [4];
        int nb, nc;

        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [17];
        logic [0:17] i0, i1, i2, j0, j1, k0, k1, k2, k0n, bad, s0;
        logic [0:17] m [4];
        int nb, nc;

        i0 = w(3, 2, 1, 0);  i1 = w(6, 5, 4, 0);  i2 = w(9, 8, 7, 0);
        j0 = w(3, 2, 5, 0);  j1 = w(6, 5, 10, 0);
        k0 = w(3, 2, 5, 0);  k1 = w(7, 6, 8, 0);  k2 = w(5, 9, 11, 0);
        k0n = w(3, 2, 5, 5);
        m[0] = w(3, 2, 1, 0);  m[1] = w(6, 5, 4, 0);
        m[2] = w(9, 8, 7, 0);  m[3] = w(12, 11, 10, 0);
        bad = w(0, 0, 0, 6);
        s0  = w(1, 1, 2, 0);

        // Independent 3-word program, then a distance-1 hazard program.
        tbl[0]  = mk(1, 0, i0, 0, 0, NOP, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, i1, 0, 0, NOP, 0, 0, 0, 0);
        tbl[2]  = mk(1, 2, i2, 0, 0, NOP, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0,  1, 2, i0,  1, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0,  0, 0, i1,  2, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0,  0, 0, i2,  2, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0,  0, 0, NOP, 2, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0,  0, 0, NOP, 2, 0, 0, 1);
        tbl[8]  = mk(0, 0, 0,  0, 0, NOP, 2, 0, 0, 0);
        tbl[9]  = mk(1, 0, j0, 0, 0, NOP, 2, 0, 0, 0);
        tbl[10] = mk(1, 1, j1, 0, 0, NOP, 2, 0, 0, 0);
        tbl[11] = mk(0, 0, 0,  1, 1, j0,  1, 1, 0, 0);
        tbl[12] = mk(0, 0, 0,  0, 0, NOP, 1, 1, 1, 0);
        tbl[13] = mk(0, 0, 0,  0, 0, NOP, 1, 1, 1, 0);
        tbl[14] = mk(0, 0, 0,  0, 0, j1,  1, 1, 0, 0);
        tbl[15] = mk(0, 0, 0,  0, 0, NOP, 1, 1, 0, 0);
        tbl[16] = mk(0, 0, 0,  0, 0, NOP, 1, 0, 0, 1);

        rst_jericalla = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; last_addr = '0;
        tick();
        tick();
        check("rst_instr", instruccion, NOP);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_bubble", bubble, 0);
        check("rst_done", done, 0);
        rst_jericalla = 1'b0;

        for (int i = 0; i < 17; i++) begin
            load_we = tbl[i].we; load_addr = tbl[i].addr; load_data = tbl[i].data;
            start = tbl[i].st;   last_addr = tbl[i].last;
            tick();
            check($sformatf("r%0d_instr", i), instruccion, tbl[i].e_instr);
            check($sformatf("r%0d_pc", i), pc, tbl[i].e_pc);
            check($sformatf("r%0d_busy", i), busy, tbl[i].e_busy);
            check($sformatf("r%0d_bubble", i), bubble, tbl[i].e_bub);
            check($sformatf("r%0d_done", i), done, tbl[i].e_done);
        end
        load_we = 1'b0; start = 1'b0;
        tick();

        // Distance-2 hazard: one bubble before k2.
        load(0, k0); load(1, k1); load(2, k2);
        run_capture(2, nb, nc);
        check("d2_bubbles", nb, 1);
        check("d2_k1", cap[1], k1);
        check("d2_bub_nop", cap[2], NOP);
        check("d2_k2", cap[3], k2);
        check("d2_edges", nc, 6);

        // Same program, producer opcode outside the writeback mask.
        load(0, k0n);
        run_capture(2, nb, nc);
        check("nowb_bubbles", nb, 0);
        check("nowb_k2", cap[2], k2);
        check("nowb_edges", nc, 5);

        // Reset while the second word of a 4-word program issues.
        for (int i = 0; i < 4; i++) load(i, m[i]);
        start = 1'b1; last_addr = 6'd3;
        tick();
        start = 1'b0;
        check("mr_m0", instruccion, m[0]);
        tick();
        check("mr_m1", instruccion, m[1]);
        rst_jericalla = 1'b1;
        tick();
        rst_jericalla = 1'b0;
        check("mr_instr", instruccion, NOP);
        check("mr_pc", pc, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mr_nodone%0d", i), done, 0);
        end
        run_capture(3, nb, nc);
        check("mr_rerun_m0", cap[0], m[0]);
        check("mr_rerun_m3", cap[3], m[3]);
        check("mr_rerun_edges", nc, 6);

        // Write attempts while busy and together with start must be dropped.
        start = 1'b1; last_addr = 6'd3;
        tick();
        start = 1'b0;
        load_we = 1'b1; load_addr = 6'd0; load_data = bad;
        tick();
        load_we = 1'b0;
        wait_idle("intl_busy_idle");
        run_capture(3, nb, nc);
        check("intl_busy_m0", cap[0], m[0]);
        tick();
        load_we = 1'b1; load_addr = 6'd0; load_data = bad;
        run_capture(3, nb, nc);
        run_capture(3, nb, nc);
        check("intl_start_m0", cap[0], m[0]);

        // Single-instruction program; start during drain is ignored.
        tick();
        load(0, s0);
        start = 1'b1; last_addr = 6'd0;
        tick();
        check("one_s0", instruccion, s0);
        check("one_busy", busy, 1);
        last_addr = 6'd5;
        tick();
        check("one_nop1", instruccion, NOP);
        check("one_nodone", done, 0);
        tick();
        check("one_nop2", instruccion, NOP);
        check("one_done", done, 1);
        check("one_busy_fall", busy, 0);
        start = 1'b0;
        tick();
        check("one_ignored_instr", instruccion, NOP);
        check("one_ignored_busy", busy, 0);
        check("one_done_pulse", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
